// File: rtl/window_conv.sv
// -----------------------------------------------------------------------------
// window_conv
//   Builds a KxK sliding window from the K-pixel columns delivered by the
//   row-buffer top, convolves it with a signed KxK kernel and emits one
//   clamped pixel per complete window.
//
//   Pipeline (one column accepted per clock at most):
//     stage 1 : window shift register + column counter + valid/eol tags
//     stage 2 : K*K signed products
//     stage 3 : sum of products
//     stage 4 : arithmetic shift, clamp to [0, 2^PIXEL_WIDTH-1], output regs
//   A column accepted at edge n appears on pix_out at edge n+3.
//
//   Handshake: col_valid qualifies col_in for one cycle; there is no
//   back-pressure, so the consumer must take pix_out whenever pix_valid=1.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset, highest priority
//   start      frame start: clears column count and stage-1 tags
//   col_valid  column strobe
//   col_in     K pixels, pixel r at [r*PIXEL_WIDTH +: PIXEL_WIDTH], r=0 top
//   coef       signed kernel, entry (r,c) at index r*K+c, c=K-1 newest column
//   pix_valid  pix_out valid this cycle
//   pix_out    filtered, saturated pixel (holds between valid outputs)
//   eol        high with the last output of each image row
// -----------------------------------------------------------------------------
module window_conv #(
   parameter int K           = 3,
   parameter int PIXEL_WIDTH = 8,
   parameter int COEF_WIDTH  = 8,
   parameter int IMG_WIDTH   = 512,
   parameter int SHIFT       = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          col_valid,
   input  logic [K*PIXEL_WIDTH-1:0]      col_in,
   input  logic [K*K*COEF_WIDTH-1:0]     coef,
   output logic                          pix_valid,
   output logic [PIXEL_WIDTH-1:0]        pix_out,
   output logic                          eol
);

   localparam int N      = K * K;
   localparam int CNT_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int PROD_W = PIXEL_WIDTH + COEF_WIDTH + 1;
   localparam int SUM_W  = PIXEL_WIDTH + COEF_WIDTH + $clog2(N) + 1;

   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(IMG_WIDTH - 1);
   localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(K - 1);
   localparam logic signed [SUM_W-1:0] PIX_MAX  = SUM_W'({PIXEL_WIDTH{1'b1}});

   // ---------------- stage 1: window and column counter ----------------
   logic [PIXEL_WIDTH-1:0] win_q [K][K];   // [row][col], col K-1 newest
   logic [CNT_W-1:0]       col_cnt_q, col_cnt_d, cnt_base;
   logic                   win_v_q, win_v_d;
   logic                   win_eol_q, win_eol_d;

   always_comb begin
      // start restarts counting; a column strobed with start becomes column 0
      cnt_base  = start ? '0 : col_cnt_q;
      col_cnt_d = cnt_base;
      if (col_valid) begin
         col_cnt_d = (cnt_base == CNT_LAST) ? '0 : cnt_base + CNT_W'(1);
      end
      // the first K-1 columns of a row never form a complete window
      win_v_d   = col_valid && !start && (col_cnt_q >= CNT_FULL);
      win_eol_d = col_valid && !start && (col_cnt_q == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_q[r][c] <= '0;
            end
         end
         col_cnt_q <= '0;
         win_v_q   <= 1'b0;
         win_eol_q <= 1'b0;
      end else begin
         if (col_valid) begin
            for (int r = 0; r < K; r++) begin
               for (int c = 0; c < K - 1; c++) begin
                  win_q[r][c] <= win_q[r][c+1];
               end
               win_q[r][K-1] <= col_in[r*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
         end
         col_cnt_q <= col_cnt_d;
         win_v_q   <= win_v_d;
         win_eol_q <= win_eol_d;
      end
   end

   // ---------------- stage 2: products ----------------
   logic signed [PROD_W-1:0] prod_d [N];
   logic signed [PROD_W-1:0] prod_q [N];
   logic                     v2_q, eol2_q;

   always_comb begin
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            // pixel is unsigned: prepend a zero so it stays positive when signed
            prod_d[r*K+c] = PROD_W'($signed({1'b0, win_q[r][c]}))
                          * PROD_W'($signed(coef[(r*K+c)*COEF_WIDTH +: COEF_WIDTH]));
         end
      end
   end

   // ---------------- stage 3: sum ----------------
   logic signed [SUM_W-1:0] sum_d, sum_q;
   logic                    v3_q, eol3_q;

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < N; i++) begin
         sum_d = sum_d + SUM_W'(prod_q[i]);
      end
   end

   // ---------------- stage 4: shift and clamp ----------------
   logic signed [SUM_W-1:0] shifted;
   logic [PIXEL_WIDTH-1:0]  pix_d;
   logic [PIXEL_WIDTH-1:0]  pix_out_q;
   logic                    pix_valid_q, eol_q;

   always_comb begin
      shifted = sum_q >>> SHIFT;
      if (shifted < 0) begin
         pix_d = '0;
      end else if (shifted > PIX_MAX) begin
         pix_d = '1;
      end else begin
         pix_d = shifted[PIXEL_WIDTH-1:0];
      end
   end

   // stages 2-4 advance every cycle; only the tags decide what is visible
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            prod_q[i] <= '0;
         end
         v2_q        <= 1'b0;
         eol2_q      <= 1'b0;
         sum_q       <= '0;
         v3_q        <= 1'b0;
         eol3_q      <= 1'b0;
         pix_out_q   <= '0;
         pix_valid_q <= 1'b0;
         eol_q       <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            prod_q[i] <= prod_d[i];
         end
         v2_q   <= win_v_q;
         eol2_q <= win_eol_q;
         sum_q  <= sum_d;
         v3_q   <= v2_q;
         eol3_q <= eol2_q;
         if (v3_q) begin
            pix_out_q <= pix_d;
         end
         pix_valid_q <= v3_q;
         eol_q       <= v3_q && eol3_q;
      end
   end

   assign pix_valid = pix_valid_q;
   assign pix_out   = pix_out_q;
   assign eol       = eol_q;

endmodule

// File: tb/tb_window_conv.sv
// -----------------------------------------------------------------------------
// tb_window_conv
//   Two window_conv instances (SHIFT=0 and SHIFT=3) share one stimulus
//   stream. A behavioural model keeps the last K accepted columns, computes
//   each expected output with plain integer arithmetic when its column is
//   driven, and queues it with the edge number it is due on. A compare
//   process checks both instances after every rising edge. Phase checks pin
//   hand-computed values, output counts, latency and spacing.
// -----------------------------------------------------------------------------
module tb_window_conv;

   localparam int K    = 3;
   localparam int PW   = 8;
   localparam int CW   = 8;
   localparam int IMGW = 8;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst_n, start, col_valid;
   logic [K*PW-1:0]   col_in;
   logic [K*K*CW-1:0] coef;
   logic              pix_valid0, eol0, pix_valid3, eol3;
   logic [PW-1:0]     pix_out0, pix_out3;

   always #5 clk = ~clk;

   int cyc = 0;   // number of rising edges seen so far
   always @(posedge clk) cyc <= cyc + 1;

   window_conv #(.K(K), .PIXEL_WIDTH(PW), .COEF_WIDTH(CW), .IMG_WIDTH(IMGW), .SHIFT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .col_valid(col_valid), .col_in(col_in),
      .coef(coef), .pix_valid(pix_valid0), .pix_out(pix_out0), .eol(eol0));

   window_conv #(.K(K), .PIXEL_WIDTH(PW), .COEF_WIDTH(CW), .IMG_WIDTH(IMGW), .SHIFT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .col_valid(col_valid), .col_in(col_in),
      .coef(coef), .pix_valid(pix_valid3), .pix_out(pix_out3), .eol(eol3));

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   int          coef_arr [K*K];
   logic [PW-1:0] hist [K][K];        // [col][row], col K-1 newest
   int          m_cnt = 0;
   int          due_q [$];            // edge on which each expected output appears
   logic [16:0] exp_q [$];            // {eol, value SHIFT=3, value SHIFT=0}
   logic [7:0]  hold0 = 8'd0;
   logic [7:0]  hold3 = 8'd0;
   int          acc_edges [$];

   // observations for phase checks
   int          n_valid, n_eol, first_valid;
   logic [7:0]  last0, last3;
   int          valid_edges [$];
   int          seen_q [$];
   int          cont_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] clampsh(input int s, input int sh);
      int t;
      t = s >>> sh;
      if (t < 0) return 8'd0;
      if (t > 255) return 8'd255;
      return t[7:0];
   endfunction

   function automatic logic [K*PW-1:0] colp(input int p0, input int p1, input int p2);
      return {8'(p2), 8'(p1), 8'(p0)};
   endfunction

   function automatic logic [K*PW-1:0] ramp(input int j);
      return colp(j*j, j*j + 1, j*j + 2);
   endfunction

   task automatic pack_coef();
      for (int i = 0; i < K*K; i++) coef[i*CW +: CW] = CW'(coef_arr[i]);
   endtask

   task automatic begin_phase();
      n_valid = 0;
      n_eol = 0;
      first_valid = -1;
      acc_edges.delete();
      valid_edges.delete();
      seen_q.delete();
   endtask

   // ---------------- driver + model ----------------
   task automatic step(input bit v, input logic [K*PW-1:0] col, input bit st, input bit rs);
      int edge_n, base, s;
      @(negedge clk);
      col_valid = v;
      col_in    = col;
      start     = st;
      rst_n     = !rs;
      edge_n    = cyc + 1;
      if (rs) begin
         for (int c = 0; c < K; c++)
            for (int r = 0; r < K; r++) hist[c][r] = '0;
         m_cnt = 0;
         due_q.delete();
         exp_q.delete();
         hold0 = 8'd0;
         hold3 = 8'd0;
      end else begin
         base = st ? 0 : m_cnt;
         if (v) begin
            for (int c = 0; c < K - 1; c++) hist[c] = hist[c+1];
            for (int r = 0; r < K; r++) hist[K-1][r] = col[r*PW +: PW];
            acc_edges.push_back(edge_n);
            if (!st && base >= K - 1) begin
               s = 0;
               for (int r = 0; r < K; r++)
                  for (int c = 0; c < K; c++)
                     s += int'(hist[c][r]) * coef_arr[r*K + c];
               due_q.push_back(edge_n + 3);
               exp_q.push_back({(base == IMGW - 1), clampsh(s, 3), clampsh(s, 0)});
            end
            m_cnt = (base == IMGW - 1) ? 0 : base + 1;
         end else begin
            m_cnt = base;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, 1'b0, 1'b0);
   endtask

   // ---------------- compare process ----------------
   always @(posedge clk) begin
      logic [16:0] e;
      #1;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         e = exp_q.pop_front();
         void'(due_q.pop_front());
         chk("valid_s0", pix_valid0, 1);
         chk("pix_s0", pix_out0, e[7:0]);
         chk("eol_s0", eol0, e[16]);
         chk("valid_s3", pix_valid3, 1);
         chk("pix_s3", pix_out3, e[15:8]);
         chk("eol_s3", eol3, e[16]);
         hold0 = e[7:0];
         hold3 = e[15:8];
         n_valid++;
         if (eol0) n_eol++;
         if (first_valid < 0) first_valid = cyc;
         valid_edges.push_back(cyc);
         seen_q.push_back(int'(pix_out0));
         last0 = pix_out0;
         last3 = pix_out3;
      end else begin
         chk("idle_valid_s0", pix_valid0, 0);
         chk("idle_eol_s0", eol0, 0);
         chk("hold_s0", pix_out0, hold0);
         chk("idle_valid_s3", pix_valid3, 0);
         chk("idle_eol_s3", eol3, 0);
         chk("hold_s3", pix_out3, hold3);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int lit [6];
      lit = '{16, 32, 48, 64, 80, 96};
      rst_n = 1'b0; start = 1'b0; col_valid = 1'b0; col_in = '0;
      for (int i = 0; i < K*K; i++) coef_arr[i] = 1;
      pack_coef();
      for (int c = 0; c < K; c++)
         for (int r = 0; r < K; r++) hist[c][r] = '0;

      // reset
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);

      // box filter, constant 10, two full rows
      begin_phase();
      repeat (2*IMGW) step(1'b1, colp(10, 10, 10), 1'b0, 1'b0);
      idle(5);
      chk("box10_count", n_valid, 12);
      chk("box10_eols", n_eol, 2);
      chk("box10_val_s0", last0, 90);
      chk("box10_val_s3", last3, 11);
      chk("box10_latency", first_valid - acc_edges[2], 3);

      // saturation high, then mid-range values
      begin_phase();
      repeat (IMGW) step(1'b1, colp(200, 200, 200), 1'b0, 1'b0);
      idle(5);
      chk("box200_count", n_valid, 6);
      chk("box200_s0", last0, 255);
      chk("box200_s3", last3, 225);
      repeat (IMGW) step(1'b1, colp(16, 16, 16), 1'b0, 1'b0);
      idle(5);
      chk("box16_s0", last0, 144);
      chk("box16_s3", last3, 18);

      // Laplacian kernel
      for (int i = 0; i < K*K; i++) coef_arr[i] = -1;
      coef_arr[4] = 8;
      pack_coef();
      step(1'b0, '0, 1'b1, 1'b0);
      begin_phase();
      repeat (IMGW) step(1'b1, colp(50, 50, 50), 1'b0, 1'b0);
      idle(5);
      chk("lap50_count", n_valid, 6);
      chk("lap50_s0", last0, 0);
      step(1'b0, '0, 1'b1, 1'b0);
      begin_phase();
      step(1'b1, colp(100, 0, 0), 1'b0, 1'b0);
      step(1'b1, colp(0, 0, 0), 1'b0, 1'b0);
      step(1'b1, colp(0, 0, 0), 1'b0, 1'b0);
      idle(5);
      chk("corner_count", n_valid, 1);
      chk("corner_s0", last0, 0);
      step(1'b0, '0, 1'b1, 1'b0);
      begin_phase();
      step(1'b1, colp(0, 0, 0), 1'b0, 1'b0);
      step(1'b1, colp(0, 100, 0), 1'b0, 1'b0);
      step(1'b1, colp(0, 0, 0), 1'b0, 1'b0);
      idle(5);
      chk("centre_s0", last0, 255);
      chk("centre_s3", last3, 100);

      // horizontal gradient on j*j ramp: output for column j is 16*j-16
      coef_arr = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
      pack_coef();
      step(1'b0, '0, 1'b1, 1'b0);
      begin_phase();
      for (int j = 0; j < IMGW; j++) step(1'b1, ramp(j), 1'b0, 1'b0);
      idle(5);
      chk("ramp_count", seen_q.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < seen_q.size()) chk("ramp_lit", seen_q[i], lit[i]);
      cont_q = seen_q;

      // same row with col_valid toggling
      step(1'b0, '0, 1'b1, 1'b0);
      begin_phase();
      for (int j = 0; j < IMGW; j++) begin
         step(1'b1, ramp(j), 1'b0, 1'b0);
         step(1'b0, '0, 1'b0, 1'b0);
      end
      idle(5);
      chk("gap_count", seen_q.size(), cont_q.size());
      for (int i = 0; i < 6; i++)
         if (i < seen_q.size() && i < cont_q.size()) chk("gap_vs_cont", seen_q[i], cont_q[i]);
      for (int i = 0; i + 1 < valid_edges.size(); i++)
         chk("gap_spacing", valid_edges[i+1] - valid_edges[i], 2);
      chk("gap_latency", first_valid - acc_edges[2], 3);

      // reset after the 5th column of a row
      step(1'b0, '0, 1'b1, 1'b0);
      for (int j = 0; j < 5; j++) step(1'b1, ramp(j), 1'b0, 1'b0);
      step(1'b1, ramp(9), 1'b0, 1'b1);
      begin_phase();
      for (int j = 0; j < 5; j++) step(1'b1, ramp(j), 1'b0, 1'b0);
      idle(5);
      chk("rst_count", n_valid, 3);
      chk("rst_latency", first_valid - acc_edges[2], 3);
      chk("rst_last_s0", last0, 48);
      chk("rst_last_s3", last3, 6);

      // start together with col_valid after column 4
      step(1'b0, '0, 1'b1, 1'b0);
      begin_phase();
      for (int j = 0; j < 5; j++) step(1'b1, ramp(j), 1'b0, 1'b0);
      step(1'b1, ramp(5), 1'b1, 1'b0);
      step(1'b1, ramp(6), 1'b0, 1'b0);
      step(1'b1, ramp(7), 1'b0, 1'b0);
      idle(5);
      chk("start_count", n_valid, 4);
      chk("start_last_s0", last0, 96);
      chk("start_last_s3", last3, 12);

      chk("drained", due_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/window_conv.md
Name: window_conv

Overview:
- Consumes the K-pixel vertical column that the row-buffer top emits on each `read` cycle.
- Assembles the columns into a KxK sliding window, convolves the window with a signed KxK coefficient kernel, and emits one filtered pixel per complete window.
- Pipelined; feeds the output-pixel writer or the testbench file dump in place of raw columns.

Parameters:
K, 3, window size (rows and columns), K>=2
PIXEL_WIDTH, 8, unsigned pixel width
COEF_WIDTH, 8, signed coefficient width
IMG_WIDTH, 512, pixels per image row (columns per row delivered by top)
SHIFT, 0, arithmetic right shift applied to the accumulated sum (0..16)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  frame start; synchronously clears column counter and window-valid state
col_valid  input  1  column strobe, driven by top's `read`
col_in  input  K*PIXEL_WIDTH  column; pixel r at [(r+1)*PIXEL_WIDTH-1 -: PIXEL_WIDTH], r=0 top row
coef  input  K*K*COEF_WIDTH  signed kernel, static during a frame; entry (r,c) at index r*K+c, c=K-1 newest column
pix_valid  output  1  pix_out valid this cycle
pix_out  output  PIXEL_WIDTH  filtered, saturated pixel
eol  output  1  high with the last pix_out of each image row

Behaviour:
- Reset (rst_n=0 at a rising edge) clears:
  - window registers to 0 and col_cnt to 0;
  - all pipeline valid/eol tags to 0;
  - pix_valid=0, pix_out=0, eol=0.
- rst_n has priority over everything. Reset mid-operation discards all in-flight results; no pix_valid until K new columns have been accepted.
- Acceptance: at an edge with col_valid=1:
  - window columns shift left (c <- c+1), col_in loads into column K-1;
  - col_cnt increments, wrapping IMG_WIDTH-1 -> 0.
- Stage-1 tag: win_v = (col_cnt before increment >= K-1); win_eol = (col_cnt before increment == IMG_WIDTH-1).
- At an edge with col_valid=0, window and col_cnt hold and win_v=0.
- No clearing of window contents at a row wrap. Window validity is suppressed for the first K-1 columns of each row, giving IMG_WIDTH-K+1 outputs per row.
- start=1 (rst_n=1): col_cnt forced to 0 and stage-1 tags forced to 0. If col_valid=1 in the same cycle, that column is still shifted in and counted as column 0, so col_cnt becomes 1. Stages 2-4 keep draining.
- Stage 2: K*K signed products p(r,c) = {1'b0,pixel} * coef(r,c), registered.
- Stage 3: adder tree sum, registered. Sum width = PIXEL_WIDTH+COEF_WIDTH+ceil(log2(K*K))+1, signed, no overflow possible.
- Stage 4: s = sum >>> SHIFT, then clamp:
  - s<0 -> 0;
  - s>2^PIXEL_WIDTH-1 -> 2^PIXEL_WIDTH-1;
  - otherwise s.
  - Result registered into pix_out.
- Latency: pix_valid and pix_out assert on the 3rd rising edge after the accepting edge. Valid and eol tags travel with the data.
- Stages 2-4 advance every cycle regardless of col_valid (no stall input; the consumer must always accept). Gaps in col_valid produce matching gaps in pix_valid, never reordering.
- Between valid outputs pix_out holds its last value; pix_valid=0 and eol=0.
- Throughput: one pixel per clock when col_valid is continuous.

Test Plan:
- K=3, IMG_WIDTH=8, all coef=1, SHIFT=0, every column 10,10,10 continuous -> first pix_valid 3 edges after the 3rd column accepted; pix_out=90; 6 outputs per row; eol on the 6th.
- Same kernel, all pixels 200 -> sum 1800, pix_out=255 (saturate high). SHIFT=3 with pixels 16 -> 144>>3 = 18.
- Laplacian (centre 8, others -1), constant 50 -> pix_out=0. Single 100 pixel at the window corner, zeros elsewhere -> sum -100, pix_out=0 (clamp low). Same 100 pixel at centre -> 800, pix_out=255.
- col_valid toggled 1/0 every other cycle with ramp pixels -> values identical to the continuous run; pix_valid spaced 2 cycles; latency still 3 edges per output.
- rst_n low for one cycle after the 5th column of a row -> pix_valid=0 and pix_out=0 next cycle; no output until 3 new columns; counting restarts at column 0.
- start pulsed together with col_valid after column 4 -> that column becomes column 0; results already in flight still emerge; next new output only after 2 more columns.
